// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - memory read port between the fetch unit and instruction memory
interface instruction_fetch_unit_if;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I fetch stage: reads the word at pc, holds it in the IR, flags faults
module instruction_fetch_unit #(
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     i_pc,
    input  logic                            i_fetch_req,
    instruction_fetch_unit_if.master        mem,
    output logic [31:0]                     o_ir,
    output logic [6:0]                      o_opcode,
    output logic [2:0]                      o_func3,
    output logic [4:0]                      o_rd,
    output logic [4:0]                      o_rs1,
    output logic [4:0]                      o_rs2,
    output logic                            o_ir_valid,
    input  logic                            i_ir_consume,
    output logic                            o_busy,
    output logic [1:0]                      o_fault,
    input  logic                            i_fault_clear
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_TMO   = 2'b10;

    state_t      r_state,    w_next_state;
    logic [31:0] r_mem_addr, w_mem_addr;
    logic        r_rd_en,    w_rd_en;
    logic [31:0] r_ir,       w_ir;
    logic        r_ir_valid, w_ir_valid;
    logic [1:0]  r_fault,    w_fault;
    logic [7:0]  r_cnt,      w_cnt;
    logic        r_busy;
    logic [7:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_addr <= 32'd0;
            r_rd_en    <= 1'b0;
            r_ir       <= RESET_INSTR;
            r_ir_valid <= 1'b0;
            r_fault    <= FAULT_NONE;
            r_cnt      <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mem_addr <= w_mem_addr;
            r_rd_en    <= w_rd_en;
            r_ir       <= w_ir;
            r_ir_valid <= w_ir_valid;
            r_fault    <= w_fault;
            r_cnt      <= w_cnt;
            r_busy     <= (w_next_state == ST_REQ) || (w_next_state == ST_HOLD);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_addr   = r_mem_addr;
        w_rd_en      = r_rd_en;
        w_ir         = r_ir;
        w_ir_valid   = r_ir_valid;
        w_fault      = r_fault;
        w_cnt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_fetch_req) begin
                    if (i_pc[1:0] == 2'b00) begin
                        w_mem_addr   = i_pc;
                        w_rd_en      = 1'b1;
                        w_cnt        = 8'd0;
                        w_next_state = ST_REQ;
                    end else begin
                        w_fault      = FAULT_ALIGN;
                        w_next_state = ST_FAULT;
                    end
                end
            end
            ST_REQ: begin
                // A response in the same cycle as the last allowed wait beats the timeout.
                if (mem.mem_ready) begin
                    w_ir         = mem.mem_rdata;
                    w_ir_valid   = 1'b1;
                    w_rd_en      = 1'b0;
                    w_cnt        = 8'd0;
                    w_next_state = ST_HOLD;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_rd_en      = 1'b0;
                    w_fault      = FAULT_TMO;
                    w_cnt        = 8'd0;
                    w_next_state = ST_FAULT;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            ST_HOLD: begin
                if (i_ir_consume) begin
                    w_ir_valid   = 1'b0;
                    w_next_state = ST_IDLE;
                    if (i_fetch_req) begin
                        if (i_pc[1:0] == 2'b00) begin
                            w_mem_addr   = i_pc;
                            w_rd_en      = 1'b1;
                            w_cnt        = 8'd0;
                            w_next_state = ST_REQ;
                        end else begin
                            w_fault      = FAULT_ALIGN;
                            w_next_state = ST_FAULT;
                        end
                    end
                end
            end
            ST_FAULT: begin
                w_rd_en    = 1'b0;
                w_ir_valid = 1'b0;
                if (i_fault_clear) begin
                    w_fault      = FAULT_NONE;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_rd_en = r_rd_en;
    assign o_ir          = r_ir;
    assign o_ir_valid    = r_ir_valid;
    assign o_fault       = r_fault;
    assign o_busy        = r_busy;
    assign o_opcode      = r_ir[6:0];
    assign o_func3       = r_ir[14:12];
    assign o_rd          = r_ir[11:7];
    assign o_rs1         = r_ir[19:15];
    assign o_rs2         = r_ir[24:20];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_req;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd, rs1, rs2;
    logic        ir_valid;
    logic        ir_consume;
    logic        busy;
    logic [1:0]  fault;
    logic        fault_clear;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_fault;
        logic [1:0]  fcode;
        logic [31:0] ir;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ev_t;

    ev_t         ev_q[$];
    logic [31:0] addr_q[$];

    instruction_fetch_unit_if mif();

    instruction_fetch_unit #(.TIMEOUT(15), .RESET_INSTR(32'h0000_0013)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (pc),
        .i_fetch_req  (fetch_req),
        .mem          (mif),
        .o_ir         (ir),
        .o_opcode     (opcode),
        .o_func3      (func3),
        .o_rd         (rd),
        .o_rs1        (rs1),
        .o_rs2        (rs2),
        .o_ir_valid   (ir_valid),
        .i_ir_consume (ir_consume),
        .o_busy       (busy),
        .o_fault      (fault),
        .i_fault_clear(fault_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] w, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        ev_t e;
        e.is_fault = 1'b0; e.fcode = 2'b00; e.ir = w; e.op = op; e.f3 = f3;
        e.rd = d; e.rs1 = s1; e.rs2 = s2;
        ev_q.push_back(e);
    endtask

    task automatic push_fault(input logic [1:0] code);
        ev_t e;
        e.is_fault = 1'b1; e.fcode = code; e.ir = 32'd0; e.op = 7'd0; e.f3 = 3'd0;
        e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0;
        ev_q.push_back(e);
    endtask

    // Monitor: pops an expectation on every rising ir_valid, new fault, or new memory request.
    logic       prev_valid = 1'b0;
    logic       prev_rd_en = 1'b0;
    logic [1:0] prev_fault = 2'b00;
    always @(negedge clk) begin
        ev_t e;
        logic [31:0] a;
        if (!rst) begin
            if (mif.mem_rd_en && !prev_rd_en) begin
                if (addr_q.size() == 0) chk("unexpected_mem_req", 32'd1, 32'd0);
                else begin
                    a = addr_q.pop_front();
                    chk("mem_addr", mif.mem_addr, a);
                end
            end
            if (ir_valid && !prev_valid) begin
                if (ev_q.size() == 0) chk("unexpected_ir_valid", 32'd1, 32'd0);
                else begin
                    e = ev_q.pop_front();
                    chk("ev_kind_fetch", {31'd0, e.is_fault}, 32'd0);
                    chk("ir", ir, e.ir);
                    chk("opcode", {25'd0, opcode}, {25'd0, e.op});
                    chk("func3", {29'd0, func3}, {29'd0, e.f3});
                    chk("rd", {27'd0, rd}, {27'd0, e.rd});
                    chk("rs1", {27'd0, rs1}, {27'd0, e.rs1});
                    chk("rs2", {27'd0, rs2}, {27'd0, e.rs2});
                end
            end
            if (fault != 2'b00 && prev_fault == 2'b00) begin
                if (ev_q.size() == 0) chk("unexpected_fault", {30'd0, fault}, 32'd0);
                else begin
                    e = ev_q.pop_front();
                    chk("ev_kind_fault", {31'd0, e.is_fault}, 32'd1);
                    chk("fault_code", {30'd0, fault}, {30'd0, e.fcode});
                end
            end
        end
        prev_valid = ir_valid;
        prev_rd_en = mif.mem_rd_en;
        prev_fault = fault;
    end

    initial begin
        rst = 1'b1; pc = 32'd0; fetch_req = 1'b0; ir_consume = 1'b0; fault_clear = 1'b0;
        mif.mem_ready = 1'b0; mif.mem_rdata = 32'd0;
        #12;
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_fault", {30'd0, fault}, 32'd0);
        chk("rst_rd_en", {31'd0, mif.mem_rd_en}, 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic fetch, ready two cycles after the request cycle
        pc = 32'h100; fetch_req = 1'b1;
        addr_q.push_back(32'h100);
        push_fetch(32'h00A00093, 7'h13, 3'd0, 5'd1, 5'd0, 5'd10);
        tick(); fetch_req = 1'b0; pc = 32'h500;
        chk("t1_rd_en_c1", {31'd0, mif.mem_rd_en}, 32'd1);
        tick();
        chk("t1_rd_en_c2", {31'd0, mif.mem_rd_en}, 32'd1);
        chk("t1_addr_stable", mif.mem_addr, 32'h100);
        tick();
        chk("t1_rd_en_c3", {31'd0, mif.mem_rd_en}, 32'd1);
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h00A00093;
        tick(); mif.mem_ready = 1'b0; mif.mem_rdata = 32'hDEAD_BEEF;
        chk("t1_rd_en_done", {31'd0, mif.mem_rd_en}, 32'd0);
        chk("t1_busy_hold", {31'd0, busy}, 32'd1);

        // fetch_req without consume is ignored in HOLD
        fetch_req = 1'b1; pc = 32'h200;
        tick(); fetch_req = 1'b0;
        chk("t2_hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("t2_hold_no_rd", {31'd0, mif.mem_rd_en}, 32'd0);
        // Back-to-back: consume plus request
        ir_consume = 1'b1; fetch_req = 1'b1; pc = 32'h104;
        addr_q.push_back(32'h104);
        tick(); ir_consume = 1'b0; fetch_req = 1'b0;
        chk("t2_b2b_rd_en", {31'd0, mif.mem_rd_en}, 32'd1);
        chk("t2_b2b_valid", {31'd0, ir_valid}, 32'd0);
        push_fetch(32'h00208463, 7'h63, 3'd0, 5'd8, 5'd1, 5'd2);
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h00208463;
        tick(); mif.mem_ready = 1'b0;
        ir_consume = 1'b1;
        tick(); ir_consume = 1'b0;
        chk("t2_consumed_valid", {31'd0, ir_valid}, 32'd0);
        chk("t2_ir_kept", ir, 32'h00208463);
        chk("t2_idle_busy", {31'd0, busy}, 32'd0);

        // Misaligned pc
        pc = 32'h102; fetch_req = 1'b1;
        push_fault(2'b01);
        tick(); fetch_req = 1'b0;
        chk("t3_fault", {30'd0, fault}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_no_rd_en", {31'd0, mif.mem_rd_en}, 32'd0);
            fetch_req = 1'b1; pc = 32'h300;
            tick(); fetch_req = 1'b0;
        end
        fault_clear = 1'b1;
        tick(); fault_clear = 1'b0;
        chk("t3_cleared", {30'd0, fault}, 32'd0);
        chk("t3_idle_busy", {31'd0, busy}, 32'd0);

        // Timeout: no response for 15 REQ cycles
        pc = 32'h200; fetch_req = 1'b1;
        addr_q.push_back(32'h200);
        push_fault(2'b10);
        tick(); fetch_req = 1'b0;
        chk("t4_rd_en_c1", {31'd0, mif.mem_rd_en}, 32'd1);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk("t4_rd_en_wait", {31'd0, mif.mem_rd_en}, 32'd1);
        end
        tick();
        chk("t4_tmo_rd_en", {31'd0, mif.mem_rd_en}, 32'd0);
        chk("t4_tmo_fault", {30'd0, fault}, 32'd2);
        fault_clear = 1'b1;
        tick(); fault_clear = 1'b0;

        // Response on the 15th REQ cycle beats the timeout
        pc = 32'h300; fetch_req = 1'b1;
        addr_q.push_back(32'h300);
        push_fetch(32'h00500113, 7'h13, 3'd0, 5'd2, 5'd0, 5'd5);
        tick(); fetch_req = 1'b0;
        for (int i = 2; i <= 15; i++) tick();
        chk("t4b_rd_en_c15", {31'd0, mif.mem_rd_en}, 32'd1);
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h00500113;
        tick(); mif.mem_ready = 1'b0;
        chk("t4b_no_fault", {30'd0, fault}, 32'd0);
        chk("t4b_valid", {31'd0, ir_valid}, 32'd1);
        ir_consume = 1'b1;
        tick(); ir_consume = 1'b0;

        // Asynchronous reset in the middle of REQ
        pc = 32'h400; fetch_req = 1'b1;
        addr_q.push_back(32'h400);
        tick(); fetch_req = 1'b0;
        tick();
        chk("t5_pre_rd_en", {31'd0, mif.mem_rd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_rd_en", {31'd0, mif.mem_rd_en}, 32'd0);
        chk("t5_async_ir", ir, 32'h0000_0013);
        chk("t5_async_valid", {31'd0, ir_valid}, 32'd0);
        chk("t5_async_fault", {30'd0, fault}, 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t5_idle_rd_en", {31'd0, mif.mem_rd_en}, 32'd0);

        chk("ev_q_drained", ev_q.size(), 32'd0);
        chk("addr_q_drained", addr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
